fpu_seq_core: RTL

//  Single-clock, parametrised FPU front-end: FP register file, operand select and issue sequencer.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fpu_regfile.sv | 38 +++
 rtl/fpu_seq_core.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and helpers for the FPU issue front-end.
//   fpu_state_e - sequencer state encoding
//   FP_*        - fp_alu operation selectors carried on alu_sel
//   pad_imm()   - left-justifies an immediate into the datapath width
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } fpu_state_e;

  localparam logic [2:0] FP_ADD  = 3'd0;
  localparam logic [2:0] FP_SUB  = 3'd1;
  localparam logic [2:0] FP_MUL  = 3'd2;
  localparam logic [2:0] FP_DIV  = 3'd3;
  localparam logic [2:0] FP_SQRT = 3'd4;
  localparam logic [2:0] FP_MIN  = 3'd5;
  localparam logic [2:0] FP_MAX  = 3'd6;
  localparam logic [2:0] FP_CMP  = 3'd7;

  // Works on a 64-bit container so it stays independent of the core's
  // parameters; the caller zero-extends the immediate and truncates the result.
  function automatic logic [63:0] pad_imm(input logic [63:0] imm,
                                          input int imm_w,
                                          input int reg_w);
    return imm << (reg_w - imm_w);
  endfunction

endpackage

// File: rtl/fpu_regfile.sv
// fpu_regfile: NUM_REGS x REG_W FP register file, synchronous clear.
//   cpu_clk, reset          - clock, synchronous active-high clear of all entries
//   we, waddr, wdata        - single write port, takes effect at the clock edge
//   raddr_a/b, rdata_a/b    - combinational operand read ports
//   raddr_dbg, rdata_dbg    - combinational debug read port
module fpu_regfile #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [REG_W-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [REG_W-1:0] rdata_b,
  input  logic [AW-1:0]    raddr_dbg,
  output logic [REG_W-1:0] rdata_dbg
);

  logic [REG_W-1:0] mem [NUM_REGS];

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a   = mem[raddr_a];
  assign rdata_b   = mem[raddr_b];
  assign rdata_dbg = mem[raddr_dbg];

endmodule

// File: rtl/fpu_seq_core.sv
// fpu_seq_core: FP register file, operand select and fp_alu issue sequencer.
//   Optional feature macro: FPU_TIMEOUT_EN (WAIT-state watchdog driving err).
//   cpu_clk, reset                  - clock, synchronous active-high reset
//   op_valid/op_ready + op_*        - decoded instruction handshake and fields
//   alu_start/alu_sel/alu_a/alu_b   - issue to external fp_alu
//   alu_done/alu_result             - completion from fp_alu
//   wb_valid/wb_addr/wb_data        - one-cycle writeback strobe
//   dbg_raddr/dbg_rdata             - combinational register peek
//   err                             - sticky watchdog flag
//
//   state    | meaning
//   ST_IDLE  | op_ready high, operands latched on accept
//   ST_ISSUE | alu_start pulse, watchdog loaded
//   ST_WAIT  | waiting for alu_done (or watchdog expiry)
//   ST_WB    | wb_valid, register file written at end of cycle
module fpu_seq_core
  import fpu_pkg::*;
#(
  parameter int  NUM_REGS    = 32,
  parameter int  REG_W       = 32,
  parameter int  IMM_W       = 16,
  parameter int  TIMEOUT_CYC = 64,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_ctrl,
  input  logic             op_alu_src,
  input  logic             op_reg_dst,
  input  logic [AW-1:0]    op_rs,
  input  logic [AW-1:0]    op_rt,
  input  logic [AW-1:0]    op_rd,
  input  logic [IMM_W-1:0] op_imm,
  output logic             alu_start,
  output logic [2:0]       alu_sel,
  output logic [REG_W-1:0] alu_a,
  output logic [REG_W-1:0] alu_b,
  input  logic             alu_done,
  input  logic [REG_W-1:0] alu_result,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_addr,
  output logic [REG_W-1:0] wb_data,
  input  logic [AW-1:0]    dbg_raddr,
  output logic [REG_W-1:0] dbg_rdata,
  output logic             err
);

  fpu_state_e       state, next_state;
  logic             accept, capture;
  logic [2:0]       sel_q;
  logic [AW-1:0]    dest_q;
  logic [REG_W-1:0] a_q, b_q, res_q;
  logic [REG_W-1:0] rdata_a, rdata_b, imm_pad;

  fpu_regfile #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .AW(AW)) u_regfile (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .we        (wb_valid),
    .waddr     (dest_q),
    .wdata     (res_q),
    .raddr_a   (op_rs),
    .rdata_a   (rdata_a),
    .raddr_b   (op_rt),
    .rdata_b   (rdata_b),
    .raddr_dbg (dbg_raddr),
    .rdata_dbg (dbg_rdata)
  );

  assign imm_pad = REG_W'(pad_imm(64'(op_imm), IMM_W, REG_W));

`ifdef FPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          err_q;
`endif

  always_ff @(posedge cpu_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    op_ready   = 1'b0;
    alu_start  = 1'b0;
    wb_valid   = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
`ifdef FPU_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept     = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_start  = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over an expiring watchdog in the same cycle
        if (alu_done) begin
          capture    = 1'b1;
          next_state = ST_WB;
        end
`ifdef FPU_TIMEOUT_EN
        else if (to_cnt == TW'(1)) begin
          timeout_hit = 1'b1;
          next_state  = ST_IDLE;
        end
`endif
      end
      ST_WB: begin
        wb_valid   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      sel_q  <= '0;
      dest_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        sel_q  <= op_ctrl;
        dest_q <= op_reg_dst ? op_rd : op_rt;
        a_q    <= rdata_a;
        b_q    <= op_alu_src ? imm_pad : rdata_b;
      end
      if (capture) res_q <= alu_result;
    end
  end

  assign alu_sel = sel_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign wb_addr = dest_q;
  assign wb_data = res_q;

`ifdef FPU_TIMEOUT_EN
  // Down-counter loaded in ISSUE; reaching 1 in WAIT marks the last allowed cycle.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_ISSUE)
        to_cnt <= TW'(TIMEOUT_CYC);
      else if (state == ST_WAIT && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
      if (timeout_hit) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign err = 1'b0;
`endif

endmodule
